// File: rtl/vga_timing_pkg.sv
// Raster timing constants shared by the VGA timing generator and its axis counters.
// Holds the default 800x600@72 set, a 640x480@60 alternative and the coordinate width.
package vga_timing_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    // 800x600@72 Hz from a 50 MHz pixel clock
    localparam int SVGA_H_VISIBLE = 800;
    localparam int SVGA_H_FRONT   = 56;
    localparam int SVGA_H_SYNC    = 120;
    localparam int SVGA_H_BACK    = 64;
    localparam int SVGA_V_VISIBLE = 600;
    localparam int SVGA_V_FRONT   = 37;
    localparam int SVGA_V_SYNC    = 6;
    localparam int SVGA_V_BACK    = 23;

    // 640x480@60 Hz from a 25.175 MHz pixel clock
    localparam int VGA_H_VISIBLE  = 640;
    localparam int VGA_H_FRONT    = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BACK     = 48;
    localparam int VGA_V_VISIBLE  = 480;
    localparam int VGA_V_FRONT    = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BACK     = 33;

    // Counter-derived raster flags travelling through the output delay line.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } raster_flags_t;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with visible, sync and wrap decodes.
// Used once for the horizontal axis and once, enabled by the line wrap, for the vertical axis.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = SVGA_H_VISIBLE,
    parameter int FRONT   = SVGA_H_FRONT,
    parameter int SYNC    = SVGA_H_SYNC,
    parameter int BACK    = SVGA_H_BACK
) (
    input  logic               VGA_CLOCK,
    input  logic               RESET,
    input  logic               enable,
    output logic [COORD_W-1:0] count,
    output logic               active,
    output logic               sync,
    output logic               wrap
);

    localparam int     TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t VIS_END    = coord_t'(VISIBLE);
    localparam coord_t SYNC_START = coord_t'(VISIBLE + FRONT);
    localparam coord_t SYNC_END   = coord_t'(VISIBLE + FRONT + SYNC);

    // wrap already includes enable, so the V instance's wrap marks the frame wrap.
    assign wrap   = enable && (count == LAST);
    assign active = (count < VIS_END);
    assign sync   = (count >= SYNC_START) && (count < SYNC_END);

    // NOTE: registers use <= so every flop samples pre-edge values; the reset is in
    // the sensitivity list because it must take effect without waiting for a clock.
    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (enable) begin
            count <= count + coord_t'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing for pong: coordinate bus out, engine colour back in, aligned pins out.
// Optional 8-bar colour test pattern is built when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = SVGA_H_VISIBLE,
    parameter int H_FRONT   = SVGA_H_FRONT,
    parameter int H_SYNC    = SVGA_H_SYNC,
    parameter int H_BACK    = SVGA_H_BACK,
    parameter int V_VISIBLE = SVGA_V_VISIBLE,
    parameter int V_FRONT   = SVGA_V_FRONT,
    parameter int V_SYNC    = SVGA_V_SYNC,
    parameter int V_BACK    = SVGA_V_BACK,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic               VGA_CLOCK,
    input  logic               RESET,
    input  logic [2:0]         PIXEL,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               TEST_PATTERN,
`endif
    output logic [COORD_W-1:0] PIXEL_H,
    output logic [COORD_W-1:0] PIXEL_V,
    output logic               ACTIVE,
    output logic               FRAME_START,
    output logic               VGA_HSYNC,
    output logic               VGA_VSYNC,
    output logic               VGA_R,
    output logic               VGA_G,
    output logic               VGA_B
);

    logic          h_active, h_sync, h_wrap;
    logic          v_active, v_sync, v_wrap;
    raster_flags_t flags_d1;
    logic [2:0]    colour_src;
    logic [2:0]    rgb_q;
    logic          hsync_q, vsync_q;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_counter (
        .VGA_CLOCK (VGA_CLOCK),
        .RESET     (RESET),
        .enable    (1'b1),
        .count     (PIXEL_H),
        .active    (h_active),
        .sync      (h_sync),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_counter (
        .VGA_CLOCK (VGA_CLOCK),
        .RESET     (RESET),
        .enable    (h_wrap),
        .count     (PIXEL_V),
        .active    (v_active),
        .sync      (v_sync),
        .wrap      (v_wrap)
    );

    assign ACTIVE = h_active && v_active;

`ifdef VGA_TEST_PATTERN_EN
    // Bar position tracks PIXEL_H with a small counter instead of dividing by the bar width.
    localparam coord_t BAR_LAST = coord_t'(H_VISIBLE / 8 - 1);

    coord_t     bar_px;
    logic [2:0] bar_idx;
    logic [2:0] bar_rgb_d1;

    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            bar_px     <= '0;
            bar_idx    <= '0;
            bar_rgb_d1 <= '0;
        end else begin
            bar_rgb_d1 <= ~bar_idx;
            if (h_wrap) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px  <= bar_px + coord_t'(1);
            end
        end
    end

    assign colour_src = TEST_PATTERN ? bar_rgb_d1 : PIXEL;
`else
    assign colour_src = PIXEL;
`endif

    // Stage 1 waits for the engine's registered colour; stage 2 drives the pins together.
    always_ff @(posedge VGA_CLOCK or posedge RESET) begin
        if (RESET) begin
            FRAME_START <= 1'b0;
            flags_d1    <= '0;
            rgb_q       <= '0;
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
        end else begin
            FRAME_START    <= v_wrap;
            flags_d1.active <= ACTIVE;
            flags_d1.hsync  <= h_sync;
            flags_d1.vsync  <= v_sync;
            rgb_q          <= flags_d1.active ? colour_src : 3'b000;
            hsync_q        <= flags_d1.hsync ? HSYNC_POL : ~HSYNC_POL;
            vsync_q        <= flags_d1.vsync ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    assign VGA_R     = rgb_q[2];
    assign VGA_G     = rgb_q[1];
    assign VGA_B     = rgb_q[0];
    assign VGA_HSYNC = hsync_q;
    assign VGA_VSYNC = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, shrunk and inverted-polarity rasters against a
// cycle-index model, with random engine colours and random mid-frame resets.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        bit hpol, vpol;
    } geom_t;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit TP_BUILT = 1'b1;
`else
    localparam bit TP_BUILT = 1'b0;
`endif

    function automatic geom_t geom(input int i);
        geom_t g;
        case (i)
            0:       g = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};
            1:       g = '{16, 3, 4, 5, 10, 2, 3, 2, 1'b1, 1'b1};
            default: g = '{24, 2, 6, 4, 8, 1, 2, 3, 1'b0, 1'b0};
        endcase
        return g;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        tp;
    logic [2:0]  pix [3];
    logic [10:0] ph [3];
    logic [10:0] pv [3];
    logic        act [3];
    logic        fs [3];
    logic        hs [3];
    logic        vs [3];
    logic        vr [3];
    logic        vg [3];
    logic        vb [3];

    int          n;
    int          vectors;
    int          miscompares;
    logic [2:0]  px_hist [3][4];
    logic        tp_hist [4];

    always #5 clk = ~clk;

    vga_timing_gen dut0 (
        .VGA_CLOCK (clk), .RESET (rst), .PIXEL (pix[0]),
`ifdef VGA_TEST_PATTERN_EN
        .TEST_PATTERN (tp),
`endif
        .PIXEL_H (ph[0]), .PIXEL_V (pv[0]), .ACTIVE (act[0]), .FRAME_START (fs[0]),
        .VGA_HSYNC (hs[0]), .VGA_VSYNC (vs[0]), .VGA_R (vr[0]), .VGA_G (vg[0]), .VGA_B (vb[0])
    );

    vga_timing_gen #(
        .H_VISIBLE (16), .H_FRONT (3), .H_SYNC (4), .H_BACK (5),
        .V_VISIBLE (10), .V_FRONT (2), .V_SYNC (3), .V_BACK (2),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
    ) dut1 (
        .VGA_CLOCK (clk), .RESET (rst), .PIXEL (pix[1]),
`ifdef VGA_TEST_PATTERN_EN
        .TEST_PATTERN (tp),
`endif
        .PIXEL_H (ph[1]), .PIXEL_V (pv[1]), .ACTIVE (act[1]), .FRAME_START (fs[1]),
        .VGA_HSYNC (hs[1]), .VGA_VSYNC (vs[1]), .VGA_R (vr[1]), .VGA_G (vg[1]), .VGA_B (vb[1])
    );

    vga_timing_gen #(
        .H_VISIBLE (24), .H_FRONT (2), .H_SYNC (6), .H_BACK (4),
        .V_VISIBLE (8), .V_FRONT (1), .V_SYNC (2), .V_BACK (3),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
    ) dut2 (
        .VGA_CLOCK (clk), .RESET (rst), .PIXEL (pix[2]),
`ifdef VGA_TEST_PATTERN_EN
        .TEST_PATTERN (tp),
`endif
        .PIXEL_H (ph[2]), .PIXEL_V (pv[2]), .ACTIVE (act[2]), .FRAME_START (fs[2]),
        .VGA_HSYNC (hs[2]), .VGA_VSYNC (vs[2]), .VGA_R (vr[2]), .VGA_G (vg[2]), .VGA_B (vb[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected values come straight from the raster rules applied to the cycle index n
    // since reset release (n = 0 is the cycle that presents (0,0)).
    task automatic check_inst(input int i, input bit in_reset);
        geom_t      g = geom(i);
        int         htot = g.hv + g.hf + g.hs + g.hb;
        int         vtot = g.vv + g.vf + g.vs + g.vb;
        int         h, v, hp, vp;
        bit         e_act, e_fs, e_hs, e_vs;
        logic [2:0] e_rgb;
        string      pre;

        pre = $sformatf("g%0d n=%0d rst=%0d", i, n, in_reset);
        if (in_reset) begin
            h = 0; v = 0; e_act = 1'b1; e_fs = 1'b0; e_rgb = 3'b000;
            e_hs = ~g.hpol; e_vs = ~g.vpol;
        end else begin
            h     = n % htot;
            v     = (n / htot) % vtot;
            e_act = (h < g.hv) && (v < g.vv);
            e_fs  = (n > 0) && (n % (htot * vtot) == 0);
            e_rgb = 3'b000;
            e_hs  = ~g.hpol;
            e_vs  = ~g.vpol;
            if (n >= 2) begin
                hp = (n - 2) % htot;
                vp = ((n - 2) / htot) % vtot;
                if (hp < g.hv && vp < g.vv) begin
                    if (TP_BUILT && tp_hist[(n - 1) % 4])
                        e_rgb = 3'(7 - hp / (g.hv / 8));
                    else
                        e_rgb = px_hist[i][(n - 1) % 4];
                end
                if (hp >= g.hv + g.hf && hp < g.hv + g.hf + g.hs) e_hs = g.hpol;
                if (vp >= g.vv + g.vf && vp < g.vv + g.vf + g.vs) e_vs = g.vpol;
            end
        end
        check({pre, " PIXEL_H"},     32'(ph[i]),  32'(h));
        check({pre, " PIXEL_V"},     32'(pv[i]),  32'(v));
        check({pre, " ACTIVE"},      32'(act[i]), 32'(e_act));
        check({pre, " FRAME_START"}, 32'(fs[i]),  32'(e_fs));
        check({pre, " VGA_HSYNC"},   32'(hs[i]),  32'(e_hs));
        check({pre, " VGA_VSYNC"},   32'(vs[i]),  32'(e_vs));
        check({pre, " VGA_RGB"},     32'({vr[i], vg[i], vb[i]}), 32'(e_rgb));
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            pix[i] = 3'($urandom_range(0, 7));
            px_hist[i][n % 4] = pix[i];
        end
        tp_hist[n % 4] = tp;
    endtask

    // Entered and left at a falling edge; checks land 1 ns later, well clear of the rising edge.
    task automatic run_cycles(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            #1;
            for (int i = 0; i < 3; i++) check_inst(i, 1'b0);
            drive();
            @(negedge clk);
            n++;
        end
    endtask

    task automatic reset_hold(input int cycles);
        rst = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            #1;
            for (int i = 0; i < 3; i++) check_inst(i, 1'b1);
            drive();
            @(negedge clk);
        end
        rst = 1'b0;
        n   = 0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n           = 0;
        rst         = 1'b1;
        tp          = 1'b0;
        for (int i = 0; i < 3; i++) pix[i] = 3'b000;
        @(negedge clk);

        reset_hold(3);
        run_cycles(2300);

        tp = 1'b1;
        run_cycles(1200);
        tp = 1'b0;

        repeat (3) begin
            run_cycles($urandom_range(50, 700));
            reset_hold($urandom_range(1, 3));
            run_cycles(600);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
